// File: rtl/axilite_csr_write_ctrl.sv
// AXI-Lite write front end: collects AW/W in any order, issues one CSR write, returns B.
// Optional CSR acknowledge timeout is enabled with `define AXILITE_WRITE_TIMEOUT_EN.
module axilite_csr_write_ctrl #(
  parameter int         ADDR_SIZE      = 32,
  parameter int         DATA_WIDTH     = 32,
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [1:0] RESP_SLVERR    = 2'd2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_SIZE-1:0]    s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [ADDR_SIZE-1:0]    addr,
  output logic                    addr_good,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrobe,
  output logic                    wvalid,
  input  logic                    csr_wready,
  input  logic [1:0]              csr_resp,
  input  logic                    csr_resp_valid
);

  localparam int STRB_W = DATA_WIDTH/8;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e                state_q;
  logic                  awready_q, wready_q;
  logic                  aw_held_q, w_held_q;
  logic                  aw_held_d, w_held_d;
  logic                  aw_fire, w_fire;
  logic                  wvalid_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_SIZE-1:0]  addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  timeout;

  // Readies are registered and only ever high in IDLE, so a fire implies IDLE.
  assign aw_fire   = awready_q & s_awvalid;
  assign w_fire    = wready_q & s_wvalid;
  assign aw_held_d = aw_held_q | aw_fire;
  assign w_held_d  = w_held_q | w_fire;

`ifdef AXILITE_WRITE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= '0;
    else if (state_q != ISSUE) cnt_q <= '0;
    else                       cnt_q <= cnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // The acknowledge strobe carries no information beyond csr_resp_valid.
  logic unused_ok;
  assign unused_ok = csr_wready ^ RESP_SLVERR[0] ^ TIMEOUT_CYCLES[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      wvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (aw_fire) addr_q <= s_awaddr;
          if (w_fire) begin
            wdata_q <= s_wdata;
            wstrb_q <= s_wstrb;
          end
          aw_held_q <= aw_held_d;
          w_held_q  <= w_held_d;
          if (aw_held_d && w_held_d) begin
            state_q   <= ISSUE;
            wvalid_q  <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end else begin
            awready_q <= ~aw_held_d;
            wready_q  <= ~w_held_d;
          end
        end
        ISSUE: begin
          // A real response takes priority over a timeout in the same cycle.
          if (csr_resp_valid || timeout) begin
            bresp_q   <= csr_resp_valid ? csr_resp : RESP_SLVERR;
            wvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (s_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bresp   = bresp_q;
  assign s_bvalid  = bvalid_q;
  assign addr      = addr_q;
  assign addr_good = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrobe   = wstrb_q;
  assign wvalid    = wvalid_q;

endmodule

// File: tb/tb_axilite_csr_write_ctrl.sv
// Directed bench for axilite_csr_write_ctrl: vector table plus reset/stray/timeout sequences.
module tb_axilite_csr_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_awaddr;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic [31:0] addr;
  logic        addr_good;
  logic [31:0] wdata;
  logic [3:0]  wstrobe;
  logic        wvalid;
  logic        csr_wready;
  logic [1:0]  csr_resp;
  logic        csr_resp_valid;

  int checks = 0;
  int errors = 0;
  int wv_cnt = 0;

  axilite_csr_write_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .addr(addr), .addr_good(addr_good), .wdata(wdata), .wstrobe(wstrobe), .wvalid(wvalid),
    .csr_wready(csr_wready), .csr_resp(csr_resp), .csr_resp_valid(csr_resp_valid)
  );

  always #5 clk = ~clk;

  // Counts cycles in which a CSR write request is presented.
  always @(negedge clk) if (wvalid) wv_cnt <= wv_cnt + 1;

  typedef struct {
    int          aw_dly;
    int          w_dly;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          bhold;
    bit          bearly;
    logic [1:0]  exp_bresp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input int dly, input int other_dly, input logic [31:0] a);
    bit rd;
    bit ok = 1'b0;
    repeat (dly) step();
    s_awvalid = 1'b1;
    s_awaddr  = a;
    for (int n = 0; n < 20; n++) begin
      rd = s_awready;
      step();
      if (rd) begin ok = 1'b1; break; end
    end
    s_awvalid = 1'b0;
    chk("aw_accepted", ok, 1);
    chk("awready_drop", s_awready, 0);
    if (other_dly > dly) chk("wready_stays", s_wready, 1);
  endtask

  task automatic do_w(input int dly, input int other_dly, input logic [31:0] d, input logic [3:0] s);
    bit rd;
    bit ok = 1'b0;
    repeat (dly) step();
    s_wvalid = 1'b1;
    s_wdata  = d;
    s_wstrb  = s;
    for (int n = 0; n < 20; n++) begin
      rd = s_wready;
      step();
      if (rd) begin ok = 1'b1; break; end
    end
    s_wvalid = 1'b0;
    chk("w_accepted", ok, 1);
    chk("wready_drop", s_wready, 0);
    if (other_dly > dly) chk("awready_stays", s_awready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int wv0;
    wv0 = wv_cnt;
    if (v.bearly) s_bready = 1'b1;
    fork
      do_aw(v.aw_dly, v.w_dly, v.addr);
      do_w(v.w_dly, v.aw_dly, v.data, v.strb);
    join
    chk("wvalid_e0", wvalid, 1);
    chk("addr_good_e0", addr_good, 1);
    chk("addr", addr, v.addr);
    chk("wdata", wdata, v.data);
    chk("wstrobe", wstrobe, v.strb);
    chk("bvalid_e0", s_bvalid, 0);
    step();
    chk("wvalid_e1", wvalid, 1);
    csr_wready = 1'b1; csr_resp_valid = 1'b1; csr_resp = v.resp;
    step();
    csr_wready = 1'b0; csr_resp_valid = 1'b0; csr_resp = 2'b00;
    chk("wvalid_e2", wvalid, 0);
    chk("bvalid_e2", s_bvalid, 1);
    chk("bresp", s_bresp, v.exp_bresp);
    for (int k = 0; k < v.bhold; k++) begin
      s_awvalid = 1'b1;
      s_awaddr  = 32'hBAD0_0000;
      step();
      chk("bvalid_hold", s_bvalid, 1);
      chk("bresp_hold", s_bresp, v.exp_bresp);
      chk("awready_hold", s_awready, 0);
    end
    s_awvalid = 1'b0;
    s_bready  = 1'b1;
    step();
    s_bready = 1'b0;
    chk("bvalid_done", s_bvalid, 0);
    chk("readies_back", {s_awready, s_wready}, 2'b11);
    chk("csr_write_cycles", wv_cnt - wv0, 2);
  endtask

  initial begin
    vecs[0] = '{0, 0, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 2'd0, 0, 1'b0, 2'd0};
    vecs[1] = '{3, 0, 32'h0000_0004, 32'h1234_5678, 4'h3, 2'd0, 0, 1'b0, 2'd0};
    vecs[2] = '{0, 0, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 2'd2, 5, 1'b0, 2'd2};
    vecs[3] = '{0, 2, 32'h0000_0100, 32'hA5A5_A5A5, 4'h8, 2'd1, 1, 1'b0, 2'd1};
    vecs[4] = '{1, 1, 32'h0000_FFFC, 32'h0BAD_F00D, 4'hC, 2'd3, 0, 1'b1, 2'd3};

    rst_n = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; csr_wready = 1'b0; csr_resp = '0; csr_resp_valid = 1'b0;

    #12;
    chk("reset_outputs", {s_awready, s_wready, s_bvalid, s_bresp, addr_good, wvalid,
                          addr, wdata, wstrobe}, '0);
    rst_n = 1'b1;
    #1;
    chk("readies_after_release", {s_awready, s_wready}, 2'b00);
    step();
    chk("readies_first_edge", {s_awready, s_wready}, 2'b11);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Stray CSR acknowledge in IDLE must be ignored.
    csr_wready = 1'b1; csr_resp_valid = 1'b1; csr_resp = 2'd3;
    step();
    csr_wready = 1'b0; csr_resp_valid = 1'b0; csr_resp = 2'd0;
    chk("stray_ack_bvalid", s_bvalid, 0);
    chk("stray_ack_state", {wvalid, s_awready, s_wready}, 3'b011);

    // Reset asserted during ISSUE aborts the write.
    fork
      do_aw(0, 0, 32'h0000_0040);
      do_w(0, 0, 32'h5555_AAAA, 4'hF);
    join
    chk("issue_before_abort", wvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {wvalid, addr_good, s_bvalid, s_awready, s_wready}, 5'b0);
    #2 rst_n = 1'b1;
    #1;
    chk("abort_readies_low", {s_awready, s_wready}, 2'b00);
    step();
    chk("abort_readies_back", {s_awready, s_wready}, 2'b11);
    run_vec(vecs[0]);

    // CSR never responds.
    fork
      do_aw(0, 0, 32'h0000_0080);
      do_w(0, 0, 32'h0F0F_0F0F, 4'hF);
    join
`ifdef AXILITE_WRITE_TIMEOUT_EN
    begin
      int n = 0;
      while (!s_bvalid && n < 40) begin step(); n++; end
      chk("timeout_cycles", n, 16);
      chk("timeout_bresp", s_bresp, 2);
      chk("timeout_wvalid", {wvalid, addr_good}, 2'b00);
      s_bready = 1'b1;
      step();
      s_bready = 1'b0;
      chk("timeout_bdone", s_bvalid, 0);
    end
`else
    begin
      bit seen = 1'b0;
      repeat (100) begin
        step();
        if (s_bvalid) seen = 1'b1;
      end
      chk("no_timeout_bvalid", seen, 0);
      chk("no_timeout_wvalid", wvalid, 1);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      step();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axilite_csr_write_ctrl.md
# axilite_csr_write_ctrl

AXI-Lite write-channel front end for the CSR block. It accepts the AW and W channels independently and in any order, then presents one captured address/data/strobe beat to the downstream CSR write-data stage. It waits for that stage's one-cycle `wready`/`resp` acknowledge and returns the result on the B channel. Exactly one write transaction is in flight at a time.

## Interface
Parameters:
- `ADDR_SIZE`, 32, address width.
- `DATA_WIDTH`, 32, data beat width; the strobe width is `DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, 16, maximum number of cycles to wait for the CSR acknowledge. Used only with `AXILITE_WRITE_TIMEOUT_EN`.
- `RESP_SLVERR`, 2, response code returned on timeout.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_awaddr`  in  ADDR_SIZE  AXI write address.
- `s_awvalid` / `s_awready`  in / out  1  AW handshake.
- `s_wdata`  in  DATA_WIDTH  AXI write data.
- `s_wstrb`  in  DATA_WIDTH/8  AXI byte strobes.
- `s_wvalid` / `s_wready`  in / out  1  W handshake.
- `s_bresp`  out  2  write response.
- `s_bvalid` / `s_bready`  out / in  1  B handshake.
- `addr`  out  ADDR_SIZE  captured address, driven to the CSR stage.
- `addr_good`  out  1  captured address is valid for the CSR stage.
- `wdata`  out  DATA_WIDTH  captured data.
- `wstrobe`  out  DATA_WIDTH/8  captured strobes.
- `wvalid`  out  1  write request to the CSR stage.
- `csr_wready`  in  1  one-cycle write acknowledge from the CSR stage.
- `csr_resp`  in  2  CSR response code; sampled when `csr_resp_valid` is high.
- `csr_resp_valid`  in  1  CSR response valid; asserted in the same cycle as `csr_wready`.

## Operation
- State machine states are `IDLE`, `ISSUE` and `RESP`. The reset state is `IDLE`.
- `IDLE`:
  - `s_awready = ~aw_held`, `s_wready = ~w_held`.
  - An AW handshake latches `s_awaddr` into `addr` and sets `aw_held`.
  - A W handshake latches `s_wdata` and `s_wstrb` and sets `w_held`.
  - AW and W may complete in the same cycle, or in either order with any gap between them.
  - When both flags are set after an edge, whether already held or captured at that edge, the next state is `ISSUE`.
- `ISSUE`:
  - `addr_good = wvalid = 1`.
  - On a cycle with `csr_resp_valid`, `csr_resp` is latched into `s_bresp`, and `addr_good`, `wvalid`, `aw_held` and `w_held` are cleared. The next state is `RESP`.
- `RESP`:
  - `s_bvalid = 1`, with `s_bresp` held stable.
  - On `s_bready`, the next state is `IDLE`.
- Both AXI ready outputs are 0 in `ISSUE` and `RESP`; no new AW or W beat is accepted until the B handshake completes.
- `csr_wready` or `csr_resp_valid` seen outside `ISSUE` is ignored.
- `s_bready` may be held high before `s_bvalid` rises; the B handshake then completes on the first `RESP` cycle.
- The address is forwarded unmodified. Alignment and range checking are the CSR stage's job, and its response is passed through.

## Timing
- Reset values (while `rst_n` = 0): every output is 0, including `s_awready` and `s_wready`. Both ready outputs are driven from registers and first rise one edge after `rst_n` deasserts.
- Handshake at edge E0 completes AW+W → `addr_good`/`wvalid` high after E0. The CSR stage writes at E1 and raises `csr_wready` after E1. At E2 the response is captured and `s_bvalid` rises. With `s_bready` = 1, B completes at E3 and the ready outputs are high after E3.
- Sustained throughput is one write per 4 cycles.
- Data outputs (`addr`, `wdata`, `wstrobe`) hold their captured values from capture until the next capture. They are stable for the whole time `wvalid` is high.
- Asserting `rst_n` low mid-transaction aborts immediately: held beats are discarded, `s_bvalid` = 0, and the next state is `IDLE`. No B response is issued for the aborted write.

## Configuration
- Macro: `AXILITE_WRITE_TIMEOUT_EN`.
- Defined:
  - A counter runs in `ISSUE`, cleared on entry.
  - If `TIMEOUT_CYCLES` cycles elapse without `csr_resp_valid`, `wvalid` and `addr_good` drop, `s_bresp = RESP_SLVERR`, and the next state is `RESP`.
  - If `csr_resp_valid` arrives in the same cycle the timeout fires, the CSR response wins.
- Undefined: there is no counter, and `ISSUE` waits indefinitely.

## Test plan
- AW and W in the same cycle: `addr=0x8`, `wdata=0xDEADBEEF`, `wstrb=0xF`, CSR responds OKAY → `wvalid` is high for exactly 2 cycles, `s_bvalid` rises 2 cycles after accept, `s_bresp=0`.
- W arrives 3 cycles before AW at `addr=0x4` → `s_wready` drops after the W beat, `s_awready` stays high, and exactly one CSR write occurs with correct data.
- CSR returns SLVERR (2) for `addr=0x20` → `s_bresp=2`. With `s_bready` held low for 5 cycles, `s_bvalid` and `s_bresp` stay stable and no new AW is accepted.
- `rst_n` pulsed low during `ISSUE` → `wvalid`, `addr_good` and `s_bvalid` go to 0 immediately. Ready outputs return one edge after release, and the next write completes normally.
- With `AXILITE_WRITE_TIMEOUT_EN` defined and `TIMEOUT_CYCLES=16`, `csr_resp_valid` tied low → `s_bresp=2` after 16 `ISSUE` cycles. With the macro undefined, `s_bvalid` stays 0 for 100 cycles.
